// File: rtl/motor_pwm_out.sv
// motor_pwm_out: sign-magnitude H-bridge PWM driver fed by the spline filter.
// Optional magnitude slew limiting is enabled with `define MOTOR_PWM_SLEW_EN.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                run enable (0 forces IDLE, keeps pending sample and dir)
//   din, din_valid    signed duty sample and its valid strobe
//   din_ready         pending slot empty; accept = din_valid && din_ready
//   pwm_out           registered gate drive, high cnt < active_mag (1 cycle lag)
//   dir_out           registered direction, 0 = forward, 1 = reverse
//   period_start      high on the cnt == 0 cycle of every running period
//   sat               sticky, set when the most negative sample was clamped
module motor_pwm_out #(
    parameter int DIN_W     = 14,
    parameter int DEAD_CYC  = 16,
    parameter int SLEW_STEP = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             pwm_out,
    output logic             dir_out,
    output logic             period_start,
    output logic             sat
);

    localparam int MW = DIN_W - 1;
    localparam logic [MW-1:0] MAX_CNT   = {{(MW-1){1'b1}}, 1'b0};
    localparam logic [MW-1:0] FULL_MAG  = {MW{1'b1}};
    localparam logic [MW-1:0] DEAD_LAST = MW'(DEAD_CYC - 1);

    if (DEAD_CYC < 1 || DEAD_CYC >= (2 ** MW) - 1 || SLEW_STEP < 1)
    begin : g_bad_param
        $error("motor_pwm_out: DEAD_CYC or SLEW_STEP out of range");
    end

    typedef enum logic [1:0] {IDLE, RUN, DEAD1, DEAD2} state_t;

    state_t        state, state_n;
    logic [MW-1:0] cnt, cnt_n;
    logic [MW-1:0] active_mag, mag_n;
    logic [MW-1:0] dead_cnt, dead_n;
    logic [MW-1:0] pend_mag, din_mag;
    logic          pend_valid, pend_sign;
    logic          tgt_sign, tsign_n;
    logic          dir_n, pwm_n, ps_n;
    logic          accept, din_min, load, take;
    logic          reverse, go_dead;

`ifdef MOTOR_PWM_SLEW_EN
    localparam logic [MW-1:0] STEP = MW'(SLEW_STEP);
    logic [MW-1:0] tgt_mag, tmag_n, goal;
`endif

    assign din_ready = !pend_valid;
    assign accept    = din_valid && !pend_valid;
    assign din_min   = (din == {1'b1, {MW{1'b0}}});

    // the most negative code has no positive twin; clamp it to full scale
    always_comb begin
        din_mag = din[MW-1:0];
        if (din_min)
            din_mag = FULL_MAG;
        else if (din[DIN_W-1])
            din_mag = ~din[MW-1:0] + 1'b1;
    end

    // leaving IDLE behaves like a boundary so a queued sample is applied
    assign load = en && (state == IDLE || cnt == MAX_CNT);
    assign take = load && pend_valid;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mag_n   = active_mag;
        dead_n  = dead_cnt;
        tsign_n = tgt_sign;
        dir_n   = dir_out;
        reverse = 1'b0;
        go_dead = 1'b0;
`ifdef MOTOR_PWM_SLEW_EN
        tmag_n  = tgt_mag;
        goal    = '0;
        if (take) begin
            tmag_n  = pend_mag;
            tsign_n = pend_sign;
        end
        // ramp to zero first when the target points the other way
        reverse = (tmag_n != '0) && (tsign_n != dir_out);
        goal    = reverse ? '0 : tmag_n;
        if (load) begin
            if (goal > active_mag)
                mag_n = (goal - active_mag > STEP) ?
                        active_mag + STEP : goal;
            else
                mag_n = (active_mag - goal > STEP) ?
                        active_mag - STEP : goal;
        end
        go_dead = reverse && (mag_n == '0);
`else
        if (take) begin
            mag_n   = pend_mag;
            tsign_n = pend_sign;
        end
        // a zero magnitude never flips the bridge
        reverse = (mag_n != '0) && (tsign_n != dir_out);
        go_dead = reverse;
`endif
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            mag_n   = '0;
            dead_n  = '0;
`ifdef MOTOR_PWM_SLEW_EN
            tmag_n  = '0;
`endif
        end else begin
            cnt_n = (state == IDLE || cnt == MAX_CNT) ? '0 : cnt + 1'b1;
            unique case (state)
                IDLE, RUN: begin
                    if (load) begin
                        state_n = go_dead ? DEAD1 : RUN;
                        dead_n  = '0;
                    end
                end
                DEAD1: begin
                    if (dead_cnt == DEAD_LAST) begin
                        dead_n  = '0;
                        dir_n   = ~dir_out;
                        state_n = DEAD2;
                    end else begin
                        dead_n = dead_cnt + 1'b1;
                    end
                end
                DEAD2: begin
                    if (dead_cnt == DEAD_LAST) begin
                        dead_n  = '0;
                        state_n = go_dead ? DEAD1 : RUN;
                    end else begin
                        dead_n = dead_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        // gating on the next state keeps the gate low on the edge into dead time
        pwm_n = (state == RUN) && (state_n == RUN) && (cnt < active_mag);
        ps_n  = (state_n != IDLE) && (cnt_n == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            active_mag   <= '0;
            dead_cnt     <= '0;
            tgt_sign     <= 1'b0;
            dir_out      <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            sat          <= 1'b0;
            pend_valid   <= 1'b0;
            pend_mag     <= '0;
            pend_sign    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            active_mag   <= mag_n;
            dead_cnt     <= dead_n;
            tgt_sign     <= tsign_n;
            dir_out      <= dir_n;
            pwm_out      <= pwm_n;
            period_start <= ps_n;
            sat          <= sat | (accept & din_min);
            if (accept) begin
                pend_valid <= 1'b1;
                pend_mag   <= din_mag;
                pend_sign  <= din[DIN_W-1];
            end else if (take) begin
                pend_valid <= 1'b0;
            end
        end
    end

`ifdef MOTOR_PWM_SLEW_EN
    always_ff @(posedge clk) begin
        if (rst)
            tgt_mag <= '0;
        else
            tgt_mag <= tmag_n;
    end
`endif

endmodule
